// File: rtl/elevator_request_queue_if.sv
// -----------------------------------------------------------------------------
// elevator_request_queue_if
//   Bundles the signals between the request queue and the car model.
//   The slave modport is the request queue. The master modport is the car
//   model or hall/cab button logic.
//
//   Inputs to the slave:
//     hall_up_req, hall_dn_req, cab_req_valid, cab_req_floor,
//     current_floor, current_up_ndown, deassert_floor
//   Outputs from the slave:
//     queue_status, queue_empty, next_up_ndown, pending_count, req_dropped
// -----------------------------------------------------------------------------
interface elevator_request_queue_if #(
    parameter int NUM_FLOORS = 7
);
    logic [NUM_FLOORS-1:0] hall_up_req;
    logic [NUM_FLOORS-1:0] hall_dn_req;
    logic                  cab_req_valid;
    logic [2:0]            cab_req_floor;
    logic [2:0]            current_floor;
    logic                  current_up_ndown;
    logic                  deassert_floor;
    logic [NUM_FLOORS-1:0] queue_status;
    logic                  queue_empty;
    logic                  next_up_ndown;
    logic [2:0]            pending_count;
    logic                  req_dropped;

    modport master (
        output hall_up_req, hall_dn_req, cab_req_valid, cab_req_floor,
               current_floor, current_up_ndown, deassert_floor,
        input  queue_status, queue_empty, next_up_ndown, pending_count,
               req_dropped
    );

    modport slave (
        input  hall_up_req, hall_dn_req, cab_req_valid, cab_req_floor,
               current_floor, current_up_ndown, deassert_floor,
        output queue_status, queue_empty, next_up_ndown, pending_count,
               req_dropped
    );
endinterface

// File: rtl/elevator_request_queue.sv
// -----------------------------------------------------------------------------
// elevator_request_queue
//   Latches hall and cab calls into a per-floor pending map. Floors are
//   retired while the car disembarks. A SCAN direction policy chooses the
//   car's next travel direction. All outputs are registered.
//
//   Ports:
//     clk    rising-edge system clock
//     reset  synchronous, active-high reset
//     bus    elevator_request_queue_if.slave
//            requests and car state come in; queue status and direction go out
// -----------------------------------------------------------------------------
module elevator_request_queue #(
    parameter int NUM_FLOORS = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    elevator_request_queue_if.slave bus
);
    typedef logic [NUM_FLOORS-1:0] floor_map_t;
    typedef enum logic [1:0] {IDLE, UP, DOWN} dir_state_t;

    localparam logic [2:0] TOP_FLOOR = 3'(NUM_FLOORS - 1);
    localparam floor_map_t ONE       = floor_map_t'(1);

    floor_map_t q;
    floor_map_t q_next;
    floor_map_t cab_onehot;
    floor_map_t req_vec;
    floor_map_t fresh;
    floor_map_t drop_mask;
    floor_map_t dropped;
    floor_map_t accepted;
    floor_map_t retire;
    floor_map_t cur_onehot;
    floor_map_t above_mask;
    floor_map_t below_mask;
    floor_map_t ahead_up;
    floor_map_t ahead_dn;

    logic [2:0] cur;
    logic       cur_valid;
    logic       any_up;
    logic       any_dn;
    logic       at_cur;
    logic       up_closer;
    logic [2:0] up_floor;
    logic [2:0] dn_floor;
    logic [2:0] count_next;

    dir_state_t state_q;
    dir_state_t state_d;
    logic       nud_q;
    logic       nud_d;
    logic       empty_q;
    logic [2:0] count_q;
    logic       dropped_q;

    // The latched car direction is informational only.
    logic unused_inputs;
    assign unused_inputs = bus.current_up_ndown;

    // Floor 7 is not a real floor. It retires nothing, drops nothing, and
    // counts every pending floor as lying below the car.
    assign cur        = bus.current_floor;
    assign cur_valid  = (cur <= TOP_FLOOR);
    assign cur_onehot = cur_valid ? (ONE << cur) : '0;
    assign above_mask = cur_valid ? ~((ONE << ({1'b0, cur} + 4'd1)) - ONE) : '0;
    assign below_mask = cur_valid ? (cur_onehot - ONE) : '1;

    // There is no up-call on the top floor and no down-call on the bottom floor.
    assign cab_onehot = (bus.cab_req_valid && bus.cab_req_floor <= TOP_FLOOR)
                        ? (ONE << bus.cab_req_floor) : '0;
    assign req_vec    = (bus.hall_up_req & ~(ONE << TOP_FLOOR))
                      | (bus.hall_dn_req & ~ONE)
                      | cab_onehot;

    // A call for a floor that is already pending merges silently. Only a new
    // call for the car's own floor can be dropped: the door is open there, or
    // the car is parked there with nothing else to do.
    assign fresh     = req_vec & ~q;
    assign drop_mask = (bus.deassert_floor || q == '0) ? cur_onehot : '0;
    assign dropped   = fresh & drop_mask;
    assign accepted  = fresh & ~drop_mask;
    assign retire    = bus.deassert_floor ? cur_onehot : '0;
    // Retire is applied last, so a clear wins over a set on the same floor.
    assign q_next    = (q | accepted) & ~retire;

    assign ahead_up = q_next & above_mask;
    assign ahead_dn = q_next & below_mask;
    assign any_up   = |ahead_up;
    assign any_dn   = |ahead_dn;
    assign at_cur   = |(q_next & cur_onehot);

    // NOTE: every variable written in an always_comb block gets a default
    // first. A path that leaves a variable unassigned would infer a latch.
    always_comb begin
        up_floor   = '0;
        dn_floor   = '0;
        count_next = '0;
        // Scan downward so the lowest pending floor above the car wins.
        for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
            if (ahead_up[f]) up_floor = 3'(f);
        end
        // Scan upward so the highest pending floor below the car wins.
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (ahead_dn[f]) dn_floor = 3'(f);
            count_next = count_next + 3'(q_next[f]);
        end
    end

    // This is meaningful only when both directions have work. The car then
    // lies strictly between dn_floor and up_floor. On a tie the car goes up.
    assign up_closer = (up_floor - cur) <= (cur - dn_floor);

    always_comb begin
        state_d = state_q;
        nud_d   = nud_q;
        case (state_q)
            IDLE: begin
                if (any_up && !any_dn)      state_d = UP;
                else if (any_dn && !any_up) state_d = DOWN;
                else if (any_up && any_dn)  state_d = up_closer ? UP : DOWN;
                else if (at_cur)            state_d = (cur == TOP_FLOOR) ? DOWN : UP;
            end
            UP: begin
                if (any_up)               state_d = UP;
                else if (any_dn)          state_d = DOWN;
                else if (q_next == '0)    state_d = IDLE;
            end
            DOWN: begin
                if (any_dn)               state_d = DOWN;
                else if (any_up)          state_d = UP;
                else if (q_next == '0)    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // In IDLE the car keeps its previous heading.
        if (state_d == UP)        nud_d = 1'b1;
        else if (state_d == DOWN) nud_d = 1'b0;

        // At the end floors the car can only leave one way.
        if (cur == 3'd0)          nud_d = 1'b1;
        else if (cur == TOP_FLOOR) nud_d = 1'b0;
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    // Every register then samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            q         <= '0;
            state_q   <= IDLE;
            nud_q     <= 1'b1;
            empty_q   <= 1'b1;
            count_q   <= '0;
            dropped_q <= 1'b0;
        end else begin
            q         <= q_next;
            state_q   <= state_d;
            nud_q     <= nud_d;
            empty_q   <= (q_next == '0);
            count_q   <= count_next;
            dropped_q <= |dropped;
        end
    end

    assign bus.queue_status  = q;
    assign bus.queue_empty   = empty_q;
    assign bus.next_up_ndown = nud_q;
    assign bus.pending_count = count_q;
    assign bus.req_dropped   = dropped_q;
endmodule

// File: tb/tb_elevator_request_queue.sv
// -----------------------------------------------------------------------------
// tb_elevator_request_queue
//   Directed scenarios followed by random traffic. Every cycle is checked
//   against a floor-list reference model of the queue and the SCAN policy.
// -----------------------------------------------------------------------------
module tb_elevator_request_queue;
    logic clk = 1'b0;
    logic reset;

    elevator_request_queue_if #(.NUM_FLOORS(7)) bus ();

    elevator_request_queue #(.NUM_FLOORS(7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: a list of pending floors and a heading of -1, 0 or +1.
    bit m_pend[7];
    int m_dir;
    bit m_nud;
    bit m_drop;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] m_map();
        logic [6:0] v = '0;
        for (int f = 0; f < 7; f++) v[f] = m_pend[f];
        return v;
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int f = 0; f < 7; f++) n += int'(m_pend[f]);
        return n;
    endfunction

    // Applies one clock edge, advances the model, and compares every output.
    task automatic cycle();
        bit nxt[7];
        bit req;
        bit was_empty;
        int cf;
        bit on_floor;
        bit any_up, any_dn, at_cur;
        int near_up, near_dn;

        if (reset) begin
            for (int f = 0; f < 7; f++) nxt[f] = 1'b0;
            m_dir  = 0;
            m_nud  = 1'b1;
            m_drop = 1'b0;
        end else begin
            cf        = int'(bus.current_floor);
            on_floor  = (cf < 7);
            was_empty = (m_count() == 0);
            m_drop    = 1'b0;
            for (int f = 0; f < 7; f++) begin
                nxt[f] = m_pend[f];
                req = (f < 6 && bus.hall_up_req[f]) || (f > 0 && bus.hall_dn_req[f])
                   || (bus.cab_req_valid && int'(bus.cab_req_floor) == f);
                if (req && !m_pend[f]) begin
                    if (on_floor && f == cf && (bus.deassert_floor || was_empty)) m_drop = 1'b1;
                    else nxt[f] = 1'b1;
                end
            end
            if (bus.deassert_floor && on_floor) nxt[cf] = 1'b0;

            any_up = 0; any_dn = 0; at_cur = 0; near_up = 99; near_dn = 99;
            for (int f = 0; f < 7; f++) begin
                if (!nxt[f]) continue;
                if (!on_floor) any_dn = 1;
                else if (f > cf) begin any_up = 1; if (f - cf < near_up) near_up = f - cf; end
                else if (f < cf) begin any_dn = 1; if (cf - f < near_dn) near_dn = cf - f; end
                else at_cur = 1;
            end

            if (m_dir == 0) begin
                if (any_up && !any_dn)      m_dir = 1;
                else if (any_dn && !any_up) m_dir = -1;
                else if (any_up && any_dn)  m_dir = (near_up <= near_dn) ? 1 : -1;
                else if (at_cur)            m_dir = (cf == 6) ? -1 : 1;
            end else begin
                bool_pending: begin
                    bit ahead  = (m_dir == 1) ? any_up : any_dn;
                    bit behind = (m_dir == 1) ? any_dn : any_up;
                    bit none   = !(any_up || any_dn || at_cur);
                    if (!ahead) begin
                        if (behind)    m_dir = -m_dir;
                        else if (none) m_dir = 0;
                    end
                end
            end

            if (m_dir == 1)       m_nud = 1'b1;
            else if (m_dir == -1) m_nud = 1'b0;
            if (cf == 0)          m_nud = 1'b1;
            else if (cf == 6)     m_nud = 1'b0;
        end
        for (int f = 0; f < 7; f++) m_pend[f] = nxt[f];

        @(posedge clk);
        #1;
        check("queue_status",  32'(bus.queue_status),  32'(m_map()));
        check("queue_empty",   32'(bus.queue_empty),   32'(m_count() == 0));
        check("pending_count", 32'(bus.pending_count), 32'(m_count()));
        check("next_up_ndown", 32'(bus.next_up_ndown), 32'(m_nud));
        check("req_dropped",   32'(bus.req_dropped),   32'(m_drop));
    endtask

    task automatic clear_reqs();
        bus.hall_up_req   = '0;
        bus.hall_dn_req   = '0;
        bus.cab_req_valid = 1'b0;
        bus.cab_req_floor = '0;
    endtask

    task automatic cab(input int floor);
        clear_reqs();
        bus.cab_req_valid = 1'b1;
        bus.cab_req_floor = 3'(floor);
        cycle();
        clear_reqs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_reqs();
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cf;
        clear_reqs();
        bus.current_floor    = 3'd0;
        bus.current_up_ndown = 1'b1;
        bus.deassert_floor   = 1'b0;
        reset                = 1'b1;
        #2;
        cycle();
        check("rst_status", 32'(bus.queue_status), 32'h00);
        check("rst_empty",  32'(bus.queue_empty),  32'h1);
        check("rst_nud",    32'(bus.next_up_ndown), 32'h1);
        reset = 1'b0;

        // A cab call for floor 4 from floor 0.
        cab(4);
        check("cab4_status", 32'(bus.queue_status),  32'b0010000);
        check("cab4_empty",  32'(bus.queue_empty),   32'h0);
        check("cab4_count",  32'(bus.pending_count), 32'h1);
        check("cab4_nud",    32'(bus.next_up_ndown), 32'h1);

        // The car heads up from 3 with 5 and 1 pending, then stops at 5.
        bus.current_floor = 3'd3;
        do_reset();
        bus.hall_up_req[5] = 1'b1;
        cycle();
        clear_reqs();
        cab(1);
        check("up_nud", 32'(bus.next_up_ndown), 32'h1);
        bus.current_floor  = 3'd5;
        bus.deassert_floor = 1'b1;
        cycle();
        check("retire5_status", 32'(bus.queue_status),  32'b0000010);
        check("retire5_nud",    32'(bus.next_up_ndown), 32'h0);
        cycle();

        // The door is open at floor 2, so an up-call there is dropped.
        bus.current_floor  = 3'd2;
        bus.hall_up_req[2] = 1'b1;
        cycle();
        check("door_drop_status", 32'(bus.queue_status), 32'b0000010);
        check("door_drop_pulse",  32'(bus.req_dropped),  32'h1);
        clear_reqs();
        cycle();
        check("door_drop_end", 32'(bus.req_dropped), 32'h0);
        bus.deassert_floor = 1'b0;

        // The car is parked at floor 6.
        bus.current_floor = 3'd6;
        do_reset();
        bus.hall_dn_req[6] = 1'b1;
        cycle();
        clear_reqs();
        check("park6_drop",   32'(bus.req_dropped),  32'h1);
        check("park6_status", 32'(bus.queue_status), 32'h00);
        cab(0);
        cab(6);
        check("top_latch_status", 32'(bus.queue_status),  32'b1000001);
        check("top_latch_nud",    32'(bus.next_up_ndown), 32'h0);
        check("top_latch_drop",   32'(bus.req_dropped),   32'h0);

        // Calls at floors 1 and 5 from 3 are equally near, so the car goes up.
        bus.current_floor = 3'd3;
        do_reset();
        bus.hall_up_req[1] = 1'b1;
        bus.hall_dn_req[5] = 1'b1;
        cycle();
        clear_reqs();
        check("tie_nud",    32'(bus.next_up_ndown), 32'h1);
        check("tie_status", 32'(bus.queue_status),  32'b0100010);
        bus.hall_dn_req[5] = 1'b1;
        cycle();
        clear_reqs();
        check("merge_count", 32'(bus.pending_count), 32'h2);
        check("merge_drop",  32'(bus.req_dropped),   32'h0);

        // Reset while four floors are pending and a retire and a request are active.
        cab(0);
        cab(6);
        check("four_count", 32'(bus.pending_count), 32'h4);
        reset              = 1'b1;
        bus.hall_up_req[2] = 1'b1;
        bus.deassert_floor = 1'b1;
        cycle();
        check("midrst_status", 32'(bus.queue_status),  32'h00);
        check("midrst_count",  32'(bus.pending_count), 32'h0);
        check("midrst_nud",    32'(bus.next_up_ndown), 32'h1);
        reset              = 1'b0;
        bus.deassert_floor = 1'b0;
        cab(1);
        check("post_rst_status", 32'(bus.queue_status),  32'b0000010);
        check("post_rst_nud",    32'(bus.next_up_ndown), 32'h0);

        // Random traffic with a wandering car, held door openings, and floor 7.
        cf = 3;
        for (int i = 0; i < 600; i++) begin
            clear_reqs();
            for (int f = 0; f < 7; f++) begin
                bus.hall_up_req[f] = ($urandom_range(0, 99) < 8);
                bus.hall_dn_req[f] = ($urandom_range(0, 99) < 8);
            end
            bus.cab_req_valid = ($urandom_range(0, 99) < 25);
            bus.cab_req_floor = 3'($urandom_range(0, 7));
            if (bus.deassert_floor) begin
                bus.deassert_floor = ($urandom_range(0, 99) < 70);
            end else if ($urandom_range(0, 99) < 15) begin
                bus.deassert_floor = 1'b1;
            end else if ($urandom_range(0, 99) < 30) begin
                if ($urandom_range(0, 99) < 10) cf = 7;
                else if (cf == 7) cf = int'($urandom_range(0, 6));
                else if ($urandom_range(0, 1) == 1) cf = (cf < 6) ? cf + 1 : cf;
                else cf = (cf > 0) ? cf - 1 : cf;
            end
            bus.current_floor    = 3'(cf);
            bus.current_up_ndown = 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 199) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/elevator_request_queue.md
# elevator_request_queue

Request side of the elevator car interface. Latches hall-call and cab-call requests into a 7-floor pending map and drives `queue_status`, `queue_empty` and `next_up_ndown` to the car model. It consumes the car's `current_floor`, `current_up_ndown` and `deassert_floor` to retire served floors. A 3-state direction policy (SCAN: hold travel direction while requests remain ahead) decides the next direction.

## Interface
- `NUM_FLOORS`, 7, floor count; only 7 is supported, so floors are 0..6.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `hall_up_req`  in  7  per-floor up-call pulses; bit 6 ignored.
- `hall_dn_req`  in  7  per-floor down-call pulses; bit 0 ignored.
- `cab_req_valid`  in  1  cab button strobe, one request per cycle.
- `cab_req_floor`  in  3  cab target floor, sampled with `cab_req_valid`; value 7 ignored.
- `current_floor`  in  3  car position, from the car.
- `current_up_ndown`  in  1  car's latched travel direction; informational, not used for decisions.
- `deassert_floor`  in  1  car is disembarking at `current_floor`; level, may be held many cycles.
- `queue_status`  out  7  pending-floor map; bit f set means a stop is requested at floor f.
- `queue_empty`  out  1  high when `queue_status` is 0.
- `next_up_ndown`  out  1  direction the car takes on its next departure (1 = up).
- `pending_count`  out  3  population count of `queue_status`, range 0..7.
- `req_dropped`  out  1  one-cycle pulse when at least one request was discarded this cycle.

## Operation
- Reset values: `queue_status`=0, `queue_empty`=1, `next_up_ndown`=1, `pending_count`=0, `req_dropped`=0. The FSM resets to IDLE.
- Request vector each cycle: OR of `hall_up_req[5:0]`, `hall_dn_req[6:1]` and the one-hot decode of `cab_req_floor` when `cab_req_valid` is high.
- Requests for already-set bits are merged silently; they are not counted as dropped.
- Drop rules:
  - A request for `current_floor` is discarded while `deassert_floor`=1 (door open at that floor).
  - A request for `current_floor` is discarded while `queue_empty`=1 (car parked there).
  - Otherwise a request for `current_floor` is latched, because the car has already passed the stop decision.
  - `req_dropped` pulses on any discard.
- Retire: while `deassert_floor`=1, bit `current_floor` of the next state is cleared. When clear and set hit the same bit in the same cycle, clear wins.
- Next-state map: `q_next = (q | accepted) & ~retire`.
  - `queue_status`, `queue_empty` and `pending_count` are all registered from `q_next`.
- Direction FSM, evaluated on `q_next`. "above" = any bit above `current_floor`; "below" = any bit below `current_floor`.
  - IDLE: if above only, go to UP. If below only, go to DOWN. If both, go toward the nearest request, UP on a tie. If only the `current_floor` bit is set, go to UP, or to DOWN when the car is at floor 6.
  - UP: stay while above. Otherwise go to DOWN if below. Otherwise go to IDLE if `q_next`=0. Otherwise stay.
  - DOWN: mirror of UP.
  - `next_up_ndown` = 1 in UP, 0 in DOWN. In IDLE it holds its previous value.
  - Floor overrides: `next_up_ndown` is forced to 1 at floor 0 and to 0 at floor 6 in all states.
- Out-of-range `current_floor` (7): no retire, no current-floor drop. The FSM treats all bits as below.

## Timing
- Request-to-output latency: a pulse in cycle N sets `queue_status` at N+1. `queue_empty`, `pending_count` and `next_up_ndown` update in the same cycle N+1.
- Retire latency: `deassert_floor` high in cycle N clears the bit at N+1. A held `deassert_floor` keeps the bit clear and keeps dropping same-floor requests.
- `req_dropped` is registered and asserts at N+1 for a discard in cycle N.
- No backpressure: every cycle's requests are accepted or dropped; none are buffered.
- `reset` high in any cycle overrides all inputs. The next cycle shows reset values, including mid-retire and mid-request.
- All outputs are registered. There is no combinational input-to-output path.

## Test plan
- Reset, then `current_floor`=0 and `cab_req_valid`=1 with floor 4 for one cycle: next cycle `queue_status`=7'b0010000, `queue_empty`=0, `pending_count`=1, `next_up_ndown`=1.
- Car at floor 3 in UP with pending floors 5 and 1: hold `deassert_floor` at floor 5 with `current_floor`=5. Required: bit 5 clears, FSM goes to DOWN, `next_up_ndown`=0, `queue_status`=7'b0000010.
- `deassert_floor`=1 at floor 2 while `hall_up_req[2]` pulses: bit 2 stays 0 and `req_dropped`=1 for one cycle.
- Parked at floor 6 with an empty queue: `hall_dn_req[6]` is dropped. `cab_req_floor`=6 while `pending_count`=1 (floor 0) is latched, giving `queue_status`=7'b1000001 and `next_up_ndown`=0.
- From IDLE at floor 3, requests for floors 1 and 5 in the same cycle (tie): FSM goes to UP and `next_up_ndown`=1. A repeat request for floor 5 leaves `pending_count`=2 with no drop pulse.
- Assert `reset` mid-sequence with 4 floors pending: the next cycle shows all outputs at reset values, and a request the following cycle behaves as from IDLE.
